// File: rtl/gray_arb_pkg.sv
// ============================================================================
// gray_arb_pkg : shared constants and tag type for the gray-image arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package gray_arb_pkg;

  localparam int ADDR_WIDTH = 14;   // {row[6:0], col[6:0]}
  localparam int DATA_WIDTH = 8;
  localparam int IMG_WIDTH  = 128;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/gray_arb_tag_pipe.sv
// ============================================================================
// gray_arb_tag_pipe : MEM_LAT-deep {valid, port} shift register tracking
//                     outstanding SRAM reads, with per-port in-flight flags
// Revision          : 1.0
// ============================================================================
`default_nettype none

module gray_arb_tag_pipe
  import gray_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_port,
  output logic       out_valid,
  output logic       out_port,
  output logic [1:0] in_flight
);

  tag_t stage [MEM_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{valid: in_valid, port: in_port};
      for (int i = 1; i < MEM_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // The last stage counts as in flight too, so a port is never re-granted
  // in the same cycle its ready pulses.
  always_comb begin
    in_flight = 2'b00;
    for (int i = 0; i < MEM_LAT; i++) begin
      if (stage[i].valid) begin
        in_flight[stage[i].port] = 1'b1;
      end
    end
  end

  assign out_valid = stage[MEM_LAT-1].valid;
  assign out_port  = stage[MEM_LAT-1].port;

endmodule

`default_nettype wire

// File: rtl/gray_mem_arbiter.sv
// ============================================================================
// gray_mem_arbiter : two-port round-robin read arbiter in front of a shared
//                    single-port gray-image SRAM. Optional grant counters
//                    are built when GRAY_ARB_STATS_EN is defined.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = gray_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = gray_arb_pkg::DATA_WIDTH,
  parameter int MEM_LAT    = 1
`ifdef GRAY_ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ready0,
  output logic                  ready1,
  output logic [DATA_WIDTH-1:0] data0,
  output logic [DATA_WIDTH-1:0] data1,
  output logic                  mem_ce,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_q
`ifdef GRAY_ARB_STATS_EN
  , output logic [CNT_WIDTH-1:0] gnt_cnt0
  , output logic [CNT_WIDTH-1:0] gnt_cnt1
`endif
);

  logic       prio;
  logic [1:0] in_flight;
  logic [1:0] eligible;
  logic       grant;
  logic       gnt_port;
  logic       out_valid;
  logic       out_port;

  always_comb begin
    eligible = {req1 & ~in_flight[1], req0 & ~in_flight[0]};
    grant    = (|eligible) & ~reset;
    case (eligible)
      2'b11:   gnt_port = prio;
      2'b10:   gnt_port = PORT1;
      default: gnt_port = PORT0;
    endcase
  end

  assign mem_ce   = grant;
  assign mem_addr = !grant ? '0 : ((gnt_port == PORT1) ? addr1 : addr0);

  // Pointer always moves to the loser, including single-port grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= PORT0;
    end else if (grant) begin
      prio <= ~gnt_port;
    end
  end

  gray_arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant),
    .in_port   (gnt_port),
    .out_valid (out_valid),
    .out_port  (out_port),
    .in_flight (in_flight)
  );

  assign ready0 = out_valid & (out_port == PORT0);
  assign ready1 = out_valid & (out_port == PORT1);
  assign data0  = mem_q;
  assign data1  = mem_q;

`ifdef GRAY_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant) begin
      if (gnt_port == PORT0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (gnt_port == PORT1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_mem_arbiter.sv
// ============================================================================
// tb_gray_mem_arbiter : directed bench for gray_mem_arbiter (MEM_LAT 1 and 3)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_gray_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;

  logic        req0_a = 0, req1_a = 0, req0_b = 0, req1_b = 0;
  logic [13:0] addr0_a = 0, addr1_a = 0, addr0_b = 0, addr1_b = 0;
  logic        ready0_a, ready1_a, ready0_b, ready1_b;
  logic [7:0]  data0_a, data1_a, data0_b, data1_b;
  logic        mem_ce_a, mem_ce_b;
  logic [13:0] mem_addr_a, mem_addr_b;
  logic [7:0]  mem_q_a, mem_q_b, p1_b, p2_b;
`ifdef GRAY_ARB_STATS_EN
  logic [3:0]  gnt_cnt0_a, gnt_cnt1_a;
  logic [15:0] gnt_cnt0_b, gnt_cnt1_b;
`endif

  always #5 clk = ~clk;

  // SRAM models: A returns addr[7:0]^0xDB after 1 cycle, B returns addr[7:0] after 3
  always @(posedge clk) mem_q_a <= mem_addr_a[7:0] ^ 8'hDB;
  always @(posedge clk) begin
    p1_b    <= mem_addr_b[7:0];
    p2_b    <= p1_b;
    mem_q_b <= p2_b;
  end

  gray_mem_arbiter #(
    .MEM_LAT (1)
`ifdef GRAY_ARB_STATS_EN
    , .CNT_WIDTH (4)
`endif
  ) dut_a (
    .clk (clk), .reset (reset),
    .req0 (req0_a), .req1 (req1_a), .addr0 (addr0_a), .addr1 (addr1_a),
    .ready0 (ready0_a), .ready1 (ready1_a), .data0 (data0_a), .data1 (data1_a),
    .mem_ce (mem_ce_a), .mem_addr (mem_addr_a), .mem_q (mem_q_a)
`ifdef GRAY_ARB_STATS_EN
    , .gnt_cnt0 (gnt_cnt0_a), .gnt_cnt1 (gnt_cnt1_a)
`endif
  );

  gray_mem_arbiter #(
    .MEM_LAT (3)
  ) dut_b (
    .clk (clk), .reset (reset),
    .req0 (req0_b), .req1 (req1_b), .addr0 (addr0_b), .addr1 (addr1_b),
    .ready0 (ready0_b), .ready1 (ready1_b), .data0 (data0_b), .data1 (data1_b),
    .mem_ce (mem_ce_b), .mem_addr (mem_addr_b), .mem_q (mem_q_b)
`ifdef GRAY_ARB_STATS_EN
    , .gnt_cnt0 (gnt_cnt0_b), .gnt_cnt1 (gnt_cnt1_b)
`endif
  );

  // Inputs change at posedge+1; outputs are sampled at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    req0_a  = 1'b1;
    addr0_a = 14'h0081;
    req1_b  = 1'b1;
    addr1_b = 14'h0033;
    @(negedge clk);
    checks++; if (mem_ce_a !== 1'b0) begin failures++; $display("FAIL rst_ce_a got=%b exp=0", mem_ce_a); end
    checks++; if (mem_addr_a !== 14'h0) begin failures++; $display("FAIL rst_addr_a got=%h exp=0000", mem_addr_a); end
    checks++; if ({ready1_a, ready0_a} !== 2'b00) begin failures++; $display("FAIL rst_ready_a got=%b exp=00", {ready1_a, ready0_a}); end
    checks++; if (mem_ce_b !== 1'b0) begin failures++; $display("FAIL rst_ce_b got=%b exp=0", mem_ce_b); end
    checks++; if ({ready1_b, ready0_b} !== 2'b00) begin failures++; $display("FAIL rst_ready_b got=%b exp=00", {ready1_b, ready0_b}); end
`ifdef GRAY_ARB_STATS_EN
    checks++; if ({gnt_cnt1_a, gnt_cnt0_a} !== 8'h00) begin failures++; $display("FAIL rst_cnt_a got=%h exp=00", {gnt_cnt1_a, gnt_cnt0_a}); end
`endif
    next_cycle();
    reset  = 1'b0;
    req0_a = 1'b0;
    req1_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    req0_a  = 1'b1;
    addr0_a = 14'h0081;
    @(negedge clk);
    checks++; if (mem_ce_a !== 1'b1) begin failures++; $display("FAIL mid_grant_ce got=%b exp=1", mem_ce_a); end
    checks++; if (mem_addr_a !== 14'h0081) begin failures++; $display("FAIL mid_grant_addr got=%h exp=0081", mem_addr_a); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ready0_a !== 1'b0) begin failures++; $display("FAIL mid_rst_ready0 got=%b exp=0", ready0_a); end
    checks++; if (mem_ce_a !== 1'b0) begin failures++; $display("FAIL mid_rst_ce got=%b exp=0", mem_ce_a); end
    next_cycle();
    reset  = 1'b0;
    req0_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({ready0_a, mem_ce_a} !== 2'b00) begin failures++; $display("FAIL mid_after_rst cyc=%0d got=%b exp=00", k, {ready0_a, mem_ce_a}); end
      next_cycle();
    end
  endtask

  task automatic test_single();
    req0_a  = 1'b1;
    addr0_a = 14'h0081;
    @(negedge clk);
    checks++; if ({mem_ce_a, mem_addr_a} !== {1'b1, 14'h0081}) begin failures++; $display("FAIL single_grant got=%b/%h exp=1/0081", mem_ce_a, mem_addr_a); end
    checks++; if (ready0_a !== 1'b0) begin failures++; $display("FAIL single_ready_early got=%b exp=0", ready0_a); end
    next_cycle();
    @(negedge clk);
    checks++; if (ready0_a !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready0_a); end
    checks++; if (data0_a !== 8'h5A) begin failures++; $display("FAIL single_data got=%h exp=5a", data0_a); end
    checks++; if (mem_ce_a !== 1'b0) begin failures++; $display("FAIL single_inflight_ce got=%b exp=0", mem_ce_a); end
    checks++; if (ready1_a !== 1'b0) begin failures++; $display("FAIL single_ready1 got=%b exp=0", ready1_a); end
    next_cycle();
    @(negedge clk);
    checks++; if ({mem_ce_a, ready0_a} !== 2'b10) begin failures++; $display("FAIL single_regrant got=%b exp=10", {mem_ce_a, ready0_a}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({mem_ce_a, ready0_a} !== 2'b01) begin failures++; $display("FAIL single_second_ready got=%b exp=01", {mem_ce_a, ready0_a}); end
    next_cycle();
    req0_a = 1'b0;
    @(negedge clk);
    checks++; if ({mem_ce_a, ready0_a} !== 2'b00) begin failures++; $display("FAIL single_idle got=%b exp=00", {mem_ce_a, ready0_a}); end
    next_cycle();
  endtask

  task automatic test_both_lat1();
    int n0 = 0, n1 = 0;
    logic        e_ce, e_r0, e_r1;
    logic [13:0] e_addr;
    apply_reset();
    req0_a  = 1'b1;
    req1_a  = 1'b1;
    addr0_a = 14'h0102;
    addr1_a = 14'h2102;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        req0_a = 1'b0;
        req1_a = 1'b0;
      end
      e_ce   = (k < 8);
      e_addr = (k >= 8) ? 14'h0 : ((k % 2 == 0) ? 14'h0102 : 14'h2102);
      e_r0   = (k % 2 == 1);
      e_r1   = (k % 2 == 0) && (k >= 2);
      @(negedge clk);
      if (ready0_a === 1'b1) n0++;
      if (ready1_a === 1'b1) n1++;
      checks++; if ({mem_ce_a, mem_addr_a} !== {e_ce, e_addr}) begin failures++; $display("FAIL both_grant cyc=%0d got=%b/%h exp=%b/%h", k, mem_ce_a, mem_addr_a, e_ce, e_addr); end
      checks++; if ({ready1_a, ready0_a} !== {e_r1, e_r0}) begin failures++; $display("FAIL both_ready cyc=%0d got=%b exp=%b", k, {ready1_a, ready0_a}, {e_r1, e_r0}); end
      if (e_r0) begin
        checks++; if (data0_a !== 8'hD9) begin failures++; $display("FAIL both_data0 cyc=%0d got=%h exp=d9", k, data0_a); end
      end
      if (e_r1) begin
        checks++; if (data1_a !== 8'hD9) begin failures++; $display("FAIL both_data1 cyc=%0d got=%h exp=d9", k, data1_a); end
      end
      next_cycle();
    end
    checks++; if (n0 != 4) begin failures++; $display("FAIL both_count0 got=%0d exp=4", n0); end
    checks++; if (n1 != 4) begin failures++; $display("FAIL both_count1 got=%0d exp=4", n1); end
  endtask

  task automatic test_both_lat3();
    logic        e_ce, e_r0, e_r1;
    logic [13:0] e_addr;
    apply_reset();
    req0_b  = 1'b1;
    req1_b  = 1'b1;
    addr0_b = 14'h0155;
    addr1_b = 14'h20AA;
    for (int k = 0; k < 13; k++) begin
      e_ce   = (k % 4 == 0) || (k % 4 == 1);
      e_addr = (k % 4 == 0) ? 14'h0155 : ((k % 4 == 1) ? 14'h20AA : 14'h0);
      e_r0   = (k % 4 == 3);
      e_r1   = (k % 4 == 0) && (k >= 4);
      @(negedge clk);
      checks++; if ({mem_ce_b, mem_addr_b} !== {e_ce, e_addr}) begin failures++; $display("FAIL lat3_grant cyc=%0d got=%b/%h exp=%b/%h", k, mem_ce_b, mem_addr_b, e_ce, e_addr); end
      checks++; if ({ready1_b, ready0_b} !== {e_r1, e_r0}) begin failures++; $display("FAIL lat3_ready cyc=%0d got=%b exp=%b", k, {ready1_b, ready0_b}, {e_r1, e_r0}); end
      if (e_r0) begin
        checks++; if (data0_b !== 8'h55) begin failures++; $display("FAIL lat3_data0 cyc=%0d got=%h exp=55", k, data0_b); end
      end
      if (e_r1) begin
        checks++; if (data1_b !== 8'hAA) begin failures++; $display("FAIL lat3_data1 cyc=%0d got=%h exp=aa", k, data1_b); end
      end
      next_cycle();
    end
    req0_b = 1'b0;
    req1_b = 1'b0;
  endtask

`ifdef GRAY_ARB_STATS_EN
  task automatic test_stats();
    int grants = 0;
    apply_reset();
    req1_a  = 1'b1;
    addr1_a = 14'h3FFF;
    for (int k = 0; k < 100 && grants < 20; k++) begin
      @(negedge clk);
      if (mem_ce_a === 1'b1) grants++;
      next_cycle();
    end
    req1_a = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (grants != 20) begin failures++; $display("FAIL stats_grants got=%0d exp=20", grants); end
    checks++; if (gnt_cnt1_a !== 4'd15) begin failures++; $display("FAIL stats_cnt1 got=%0d exp=15", gnt_cnt1_a); end
    checks++; if (gnt_cnt0_a !== 4'd0) begin failures++; $display("FAIL stats_cnt0 got=%0d exp=0", gnt_cnt0_a); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_both_lat1();
    test_both_lat3();
`ifdef GRAY_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
